// File: rtl/msk_unshare_collect_pkg.sv
// Shared types and helpers for the masked-word unsharing collector.
package msk_unshare_collect_pkg;

  localparam int unsigned DEFAULTSHARES = 2;

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    RECOMBINE = 2'd1,
    OUTPUT    = 2'd2
  } state_t;

  // Width of the slot counter; at least one bit even for a single-word block.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/msk_unshare_collect_if.sv
// Masked-word input handshake and unmasked-block output handshake.
interface msk_unshare_collect_if
  import msk_unshare_collect_pkg::*;
#(
  parameter int unsigned d      = DEFAULTSHARES,
  parameter int unsigned W      = 32,
  parameter int unsigned NWORDS = 4
);
  logic [d*W-1:0]      in_data;
  logic                in_valid;
  logic                in_ready;
  logic [W*NWORDS-1:0] out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/msk_unshare_collect_share_xor.sv
// Combinational share recombination: bit i = XOR of in[d*i +: d].
module msk_share_xor #(
  parameter int unsigned d = 2,
  parameter int unsigned N = 32
) (
  input  logic [d*N-1:0] i_shares,
  output logic [N-1:0]   o_bits
);

  // Fold the d shares of every bit into one unmasked bit.
  always_comb begin
    o_bits = '0;
    for (int unsigned i = 0; i < N; i++) begin
      o_bits[i] = ^i_shares[d*i +: d];
    end
  end

endmodule

// File: rtl/msk_unshare_collect.sv
// Collects NWORDS masked words, recombines them only once the block is
// complete, and presents the unmasked block on a valid/ready output.
module msk_unshare_collect
  import msk_unshare_collect_pkg::*;
#(
  parameter int unsigned d      = DEFAULTSHARES,
  parameter int unsigned W      = 32,
  parameter int unsigned NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  msk_unshare_collect_if.slave bus,
  output logic                 busy
);

  localparam int unsigned CW = cnt_w(NWORDS);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_count;
  logic [d*W-1:0]      r_buf   [NWORDS];
  logic [d*W-1:0]      w_gated [NWORDS];
  logic [W*NWORDS-1:0] r_out;
  logic [W*NWORDS-1:0] w_unmasked;
  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_accept;
  logic                w_last;

  assign w_last   = (r_count == CW'(NWORDS - 1));
  assign w_accept = w_in_ready & bus.in_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= COLLECT;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; ready/valid depend on state only.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      COLLECT: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && w_last) w_state_nxt = RECOMBINE;
      end
      RECOMBINE: w_state_nxt = OUTPUT;
      OUTPUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = COLLECT;
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // Slot counter; wraps after the last word of a block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

  // Masked buffer: words stored unchanged, wiped once they are recombined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NWORDS; k++) r_buf[k] <= '0;
    end else if (r_state == RECOMBINE) begin
      for (int unsigned k = 0; k < NWORDS; k++) r_buf[k] <= '0;
    end else if (w_accept) begin
      r_buf[r_count] <= bus.in_data;
    end
  end

  // The share-XOR only ever sees the buffer while the block is complete;
  // in every other state its inputs are forced to zero.
  always_comb begin
    for (int unsigned k = 0; k < NWORDS; k++) begin
      w_gated[k] = (r_state == RECOMBINE) ? r_buf[k] : '0;
    end
  end

  for (genvar g = 0; g < NWORDS; g++) begin : g_slot
    msk_share_xor #(
      .d (d),
      .N (W)
    ) u_xor (
      .i_shares (w_gated[g]),
      .o_bits   (w_unmasked[W*g +: W])
    );
  end

  // Output register: loaded in RECOMBINE, cleared when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else if (r_state == RECOMBINE) begin
      r_out <= w_unmasked;
    end else if (r_state == OUTPUT && bus.out_ready) begin
      r_out <= '0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out;
  assign busy          = (r_state != COLLECT) || (r_count != '0);

endmodule

// File: tb/tb_msk_unshare_collect.sv
// Randomized self-checking bench for msk_unshare_collect at d = 2, 3, 4.
module tb_msk_unshare_collect;

  localparam logic [127:0] BASIC = 128'hCCDDEEFF8899AABB4455667700112233;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy2, busy3, busy4;

  msk_unshare_collect_if #(.d(2), .W(32), .NWORDS(4)) if2 ();
  msk_unshare_collect_if #(.d(3), .W(32), .NWORDS(4)) if3 ();
  msk_unshare_collect_if #(.d(4), .W(32), .NWORDS(4)) if4 ();

  msk_unshare_collect #(.d(2), .W(32), .NWORDS(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave), .busy(busy2));
  msk_unshare_collect #(.d(3), .W(32), .NWORDS(4)) u_d3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave), .busy(busy3));
  msk_unshare_collect #(.d(4), .W(32), .NWORDS(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave), .busy(busy4));

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a block is a list of accepted values; once four are
  // held the block spends one cycle recombining, then waits to be consumed.
  bit           m_accepting = 1'b1;
  bit           m_recomb    = 1'b0;
  bit           m_have_out  = 1'b0;
  logic [31:0]  m_words [$];
  logic [127:0] m_out = '0;
  logic [127:0] res   = '0;
  bit           idle_chk_en = 1'b0;

  logic [31:0] BV [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

  function automatic logic [127:0] encode(input logic [31:0] v, input logic [31:0] r0,
                                          input logic [31:0] r1, input logic [31:0] r2,
                                          input int unsigned nd);
    logic [127:0] e;
    logic         acc;
    logic         s;
    e = '0;
    for (int i = 0; i < 32; i++) begin
      acc = v[i];
      for (int j = 0; j < int'(nd) - 1; j++) begin
        s = (j == 0) ? r0[i] : (j == 1) ? r1[i] : r2[i];
        e[int'(nd)*i + j] = s;
        acc ^= s;
      end
      e[int'(nd)*i + int'(nd) - 1] = acc;
    end
    return e;
  endfunction

  task automatic check_outputs();
    logic [127:0] exp_data;
    exp_data = m_have_out ? m_out : '0;
    chk("d2_in_ready",  if2.in_ready,  m_accepting);
    chk("d2_out_valid", if2.out_valid, m_have_out);
    chk("d2_out_data",  if2.out_data,  exp_data);
    chk("d2_busy",      busy2,         !m_accepting || m_words.size() != 0);
    chk("d3_in_ready",  if3.in_ready,  m_accepting);
    chk("d3_out_valid", if3.out_valid, m_have_out);
    chk("d3_out_data",  if3.out_data,  exp_data);
    chk("d3_busy",      busy3,         !m_accepting || m_words.size() != 0);
    chk("d4_in_ready",  if4.in_ready,  m_accepting);
    chk("d4_out_valid", if4.out_valid, m_have_out);
    chk("d4_out_data",  if4.out_data,  exp_data);
    chk("d4_busy",      busy4,         !m_accepting || m_words.size() != 0);
  endtask

  // One clock: drive inputs, advance model across the edge, compare after it.
  task automatic cycle(input bit v, input bit ordy, input logic [31:0] val,
                       input logic [31:0] r0, output bit accepted);
    logic [31:0]  r1, r2;
    logic [127:0] e;
    bit           was_out;
    r1 = $urandom;
    r2 = $urandom;
    if2.in_valid = v; if3.in_valid = v; if4.in_valid = v;
    if2.out_ready = ordy; if3.out_ready = ordy; if4.out_ready = ordy;
    e = encode(val, r0, r1, r2, 2); if2.in_data = e[63:0];
    e = encode(val, r0, r1, r2, 3); if3.in_data = e[95:0];
    e = encode(val, r0, r1, r2, 4); if4.in_data = e[127:0];
    accepted = m_accepting && v;
    was_out  = m_have_out;
    @(posedge clk);
    #1;
    if (accepted) begin
      m_words.push_back(val);
      if (m_words.size() == 4) begin
        m_out = {m_words[3], m_words[2], m_words[1], m_words[0]};
        m_words.delete();
        m_accepting = 1'b0;
        m_recomb = 1'b1;
      end
    end else if (m_recomb) begin
      m_recomb = 1'b0;
      m_have_out = 1'b1;
    end else if (m_have_out && ordy) begin
      m_have_out = 1'b0;
      m_accepting = 1'b1;
    end
    check_outputs();
    if (m_have_out && !was_out) res = if2.out_data;
  endtask

  task automatic send_word(input logic [31:0] val, input logic [31:0] r0);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) cycle(1'b1, 1'b1, val, r0, acc);
    chk("send_accepted", acc, 1'b1);
  endtask

  function automatic logic [31:0] mask_for(input int mode);
    case (mode)
      0:       return 32'h00000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'hA5A5A5A5;
      default: return $urandom;
    endcase
  endfunction

  task automatic idle(input bit ordy);
    bit acc;
    cycle(1'b0, ordy, $urandom, $urandom, acc);
  endtask

  // Basic block with a chosen mask mode; checks latency and result directly.
  task automatic run_block(input int mode, input string tag);
    for (int k = 0; k < 4; k++) send_word(BV[k], mask_for(mode));
    chk({tag, "_recomb_valid"}, if2.out_valid, 1'b0);
    idle(1'b1);
    chk({tag, "_lat_valid"}, if2.out_valid, 1'b1);
    chk({tag, "_result"}, res, BASIC);
    chk({tag, "_result_d4"}, if4.out_data, BASIC);
    idle(1'b1);
    chk({tag, "_cleared"}, if2.out_data, '0);
    chk({tag, "_ready_back"}, if2.in_ready, 1'b1);
  endtask

  // Output data must read zero whenever no block is offered.
  always @(negedge clk) begin
    if (idle_chk_en) begin
      if (!if2.out_valid) chk("idle_zero_d2", if2.out_data, '0);
      if (!if3.out_valid) chk("idle_zero_d3", if3.out_data, '0);
      if (!if4.out_valid) chk("idle_zero_d4", if4.out_data, '0);
    end
  end

  initial begin
    bit   acc;
    bit   gp [7];
    int   w;
    gp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    if2.in_valid = 1'b0; if3.in_valid = 1'b0; if4.in_valid = 1'b0;
    if2.out_ready = 1'b0; if3.out_ready = 1'b0; if4.out_ready = 1'b0;
    if2.in_data = '0; if3.in_data = '0; if4.in_data = '0;
    #1 rst_n = 1'b0;
    #2;
    check_outputs();
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 idle_chk_en = 1'b1;

    // Basic block, then mask independence.
    run_block(2, "basic");
    run_block(0, "mask_zero");
    run_block(1, "mask_ones");
    run_block(3, "mask_rand");

    // Backpressure: output held while new words are offered.
    for (int k = 0; k < 4; k++) send_word(BV[k], $urandom);
    for (int c = 0; c < 11; c++) cycle(1'b1, 1'b0, $urandom, $urandom, acc);
    chk("bp_held", if2.out_data, BASIC);
    idle(1'b1);
    chk("bp_released", if2.out_valid, 1'b0);
    cycle(1'b1, 1'b1, BV[0], $urandom, acc);
    chk("bp_first_word_busy", busy2, 1'b1);
    for (int k = 1; k < 4; k++) send_word(BV[k], $urandom);
    idle(1'b1);
    chk("bp_next_result", res, BASIC);
    idle(1'b1);

    // Gapped input valid pattern.
    w = 0;
    for (int p = 0; p < 7; p++) begin
      cycle(gp[p], 1'b1, gp[p] ? BV[w] : $urandom, 32'hA5A5A5A5, acc);
      if (gp[p]) w++;
    end
    idle(1'b1);
    chk("gap_result", res, BASIC);
    idle(1'b1);

    // Reset mid-block discards the partial words.
    send_word($urandom, $urandom);
    send_word($urandom, $urandom);
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", if2.out_valid, 1'b0);
    chk("rst_out_data",  if2.out_data,  '0);
    chk("rst_busy",      busy2,         1'b0);
    chk("rst_busy_d4",   busy4,         1'b0);
    m_words.delete();
    m_accepting = 1'b1; m_recomb = 1'b0; m_have_out = 1'b0;
    check_outputs();
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    run_block(3, "post_rst");

    // Random traffic across all share counts.
    for (int c = 0; c < 400; c++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, acc);
    end
    for (int c = 0; c < 8; c++) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/msk_unshare_collect.md
# msk_unshare_collect

Output-side recombination unit for the 32-bit masked AES datapath. It receives d-share masked words from the core one word per handshake and buffers them still masked. Only after a full block has been collected does it recombine the shares into an unmasked 128-bit result. It then holds that result on a valid/ready output until it is consumed. It is the consumer end of the sharing encoding used by the masked gadgets: where the gadgets consume and produce sharings, this block removes them.

## Interface
- d, 2 (DEFAULTSHARES): number of shares.
- W, 32: unmasked word width.
- NWORDS, 4: words per block.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_data  in  d*W  masked word. Sharing of bit i is in_data[d*i +: d]; share j of bit i is in_data[d*i+j].
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a word.
- out_data  out  W*NWORDS  unmasked block. The word received k-th (k from 0) lands at out_data[W*k +: W].
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high whenever state is not COLLECT or count is not 0.

## Operation
- FSM states: COLLECT, RECOMBINE, OUTPUT. Reset state is COLLECT.
- COLLECT:
  - in_ready=1.
  - On in_valid&in_ready, store in_data unchanged (masked) into buffer slot count, then count++.
  - When the accepted word has count==NWORDS-1: count wraps to 0 and the FSM goes to RECOMBINE.
- RECOMBINE:
  - in_ready=0, out_valid=0.
  - For every bit i of every slot, out_data bit = XOR over shares of the stored sharing. The result is registered.
  - The masked buffer is cleared to 0 on the same edge.
  - Next state is OUTPUT.
- OUTPUT:
  - out_valid=1, in_ready=0.
  - out_data is held stable until out_ready.
  - On out_valid&out_ready: out_data is cleared to 0 and the FSM returns to COLLECT.
- Security rules:
  - No XOR across shares may be computed on any combinational path fed from partial buffer contents, and none may be computed before RECOMBINE.
  - The share-XOR is the only cross-share logic in the block.
  - out_data is 0 whenever out_valid=0.
- in_valid while in_ready=0 is ignored; no word is stored.
- out_ready while out_valid=0 is ignored.
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, count=0, buffer=0.
- Reset asserted mid-block discards all partial data. Collection after reset restarts at slot 0.

## Timing
- Last word is accepted on edge t. At t the FSM enters RECOMBINE. At edge t+1 out_data is loaded, out_valid goes to 1, and the FSM enters OUTPUT.
  - Latency from the last-word handshake edge to out_valid: 1 cycle of RECOMBINE.
- Output handshake on edge u: out_valid falls and in_ready rises after u. The first word of the next block can be accepted on edge u+1.
- Minimum block period: NWORDS + 2 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to in_ready.

## Structure
- Shared header msk_unshare.vh holds:
  - the state encoding constants (COLLECT=0, RECOMBINE=1, OUTPUT=2, 2 bits);
  - the count width function clog2(NWORDS).
- Sub-module msk_share_xor #(d, N): combinational, one sharing bus of d*N bits to N unmasked bits, using the bit layout above.
  - Instantiate it NWORDS times, once per buffer slot, with N=W.
- The top module contains the FSM, count, buffer and output register.

## Test plan
Notation: each word is driven with share0 = R and share1 = V^R, interleaved per the bit layout, with d=2.
- Basic block:
  - Stimulus: V = 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, R = 0xA5A5A5A5, back-to-back, out_ready=1.
  - Required: out_valid exactly 1 cycle after the 4th handshake, out_data = 0xCCDDEEFF8899AABB4455667700112233. Next cycle: out_data=0 and in_ready=1.
- Mask independence:
  - Stimulus: the same V values with R = 0x00000000, then R = 0xFFFFFFFF, then a random R per word.
  - Required: identical out_data in every case.
- Backpressure:
  - Stimulus: out_ready held 0 for 10 cycles while in_valid is held 1 with new words.
  - Required: out_data stable, in_ready=0, no words accepted; then handshake, and the next block's first word accepted on the following edge.
- Gapped input:
  - Stimulus: in_valid toggled 1,0,0,1,0,1,1.
  - Required: exactly 4 stores, same result as the basic block.
- Reset mid-block:
  - Stimulus: rst_n pulsed low after 2 words, then 4 new words.
  - Required: the result reflects only the 4 new words. During reset: out_valid=0, out_data=0, busy=0.
- Parameter sweep:
  - Stimulus: d=3 and d=4, with shares 0..d-2 random and share d-1 chosen so all shares XOR to V.
  - Required: out_data = V concatenation. A check assertion: out_data is 0 whenever out_valid=0.
